// File: rtl/tick_gen_bank.sv
// Bank of NCH runtime-programmable tick (clock-enable) generators with optional cascading.
// Optional one-shot mode is built when TICK_GEN_ONESHOT_EN is defined.
module tick_gen_bank #(
    parameter int          NCH         = 4,
    parameter int          CW          = 27,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    ce_in,
    input  logic [NCH-1:0]                          run,
    input  logic [NCH-1:0]                          cascade,
    input  logic                                    wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [CW-1:0]                           wr_div,
`ifdef TICK_GEN_ONESHOT_EN
    input  logic [NCH-1:0]                          oneshot,
    input  logic [NCH-1:0]                          arm,
`endif
    output logic [NCH-1:0]                          tick,
    output logic [NCH*CW-1:0]                       count
);

    // Channel 0 always counts ce_in, so its cascade bit has no function.
    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] div_q;
        logic          src;
        logic          eff_run;
        logic          at_top;
        logic          t;
        logic          wr_hit;

        if (i == 0) begin : g_src
            assign src = ce_in;
        end else begin : g_src
            // Ripples combinationally from the previous channel's tick.
            assign src = cascade[i] ? g_ch[i-1].t : ce_in;
        end

`ifdef TICK_GEN_ONESHOT_EN
        logic armed;
        assign eff_run = run[i] && (!oneshot[i] || armed);

        always_ff @(posedge clk) begin
            if (reset)
                armed <= 1'b0;
            else if (arm[i])
                armed <= 1'b1;
            else if (t && oneshot[i])
                armed <= 1'b0;
        end
`else
        assign eff_run = run[i];
`endif

        // div_q is never 0, so div_q-1 cannot underflow.
        assign at_top = (cnt == div_q - CW'(1));
        assign t      = !reset && eff_run && src && at_top;
        assign wr_hit = wr_en && (32'(wr_ch) == i);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                div_q <= CW'(DEFAULT_DIV);
            end else begin
                if (wr_hit)
                    div_q <= (wr_div == '0) ? CW'(1) : wr_div;

                if (wr_hit)
                    cnt <= '0;
`ifdef TICK_GEN_ONESHOT_EN
                else if (arm[i])
                    cnt <= '0;
`endif
                else if (t)
                    cnt <= '0;
                else if (eff_run && src)
                    cnt <= cnt + CW'(1);
            end
        end

        assign tick[i]             = t;
        assign count[i*CW +: CW]   = cnt;
    end

endmodule
